// File: rtl/pwm_decode.sv
// PWM receiver: synchronises an asynchronous PWM line and measures its period and high time.
// It decodes a brightness value and flags a stuck line by timeout.
module pwm_decode #(
  parameter int BITS       = 8,
  parameter int SYNC       = 2,
  parameter int MAX_PERIOD = 511
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in,
  output logic [BITS-1:0] bright,
  output logic [BITS:0]   high_count,
  output logic [BITS:0]   period,
  output logic            valid,
  output logic            locked,
  output logic            timeout
);

  localparam int CW = BITS + 1;
  localparam int WW = $clog2(SYNC + 2);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PERIOD);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [SYNC-1:0] sync_p0;
  logic            s_prev_p1;
  logic [WW-1:0]   warm;
  logic            warmed;
  logic            s;
  logic            rise;
  logic            at_limit;

  logic            cnt_clr;
  logic            cnt_run;
  logic            meas_load;
  logic            tout_load;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   hi;

  // A high time of 2^BITS or more cannot be shown in BITS bits, so it pins to full scale.
  function automatic logic [BITS-1:0] sat_bright(input logic [CW-1:0] h);
    return h[BITS] ? {BITS{1'b1}} : h[BITS-1:0];
  endfunction

  function automatic logic [BITS-1:0] stuck_bright(input logic level);
    return level ? {BITS{1'b1}} : {BITS{1'b0}};
  endfunction

  function automatic logic [CW-1:0] stuck_high(input logic level);
    return level ? MAX_CNT : {CW{1'b0}};
  endfunction

  // ---- stage p0: synchroniser chain ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC-2:0], in};
    end
  end

  assign s = sync_p0[SYNC-1];

  // ---- stage p1: delayed sample and warm-up gate for edge detect ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_prev_p1 <= 1'b0;
    end else begin
      s_prev_p1 <= s;
    end
  end

  // The chain resets to 0, so a line already high at reset would look like an edge without this gate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm <= '0;
    end else if (!warmed) begin
      warm <= warm + WW'(1);
    end
  end

  assign warmed   = (warm == WARM_DONE);
  assign rise     = s & ~s_prev_p1 & warmed;
  assign at_limit = (cnt == MAX_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, MEASURE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end else if (at_limit) begin
          state_nxt = STUCK;
        end
      end
      STUCK: begin
        if (rise) begin
          state_nxt = MEASURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters freeze on the timeout cycle and in STUCK, so cnt never passes MAX_CNT.
  always_comb begin
    cnt_clr   = rise;
    cnt_run   = 1'b0;
    meas_load = 1'b0;
    tout_load = 1'b0;
    case (state)
      IDLE: begin
        cnt_run   = ~at_limit;
        tout_load = ~rise & at_limit;
      end
      MEASURE: begin
        cnt_run   = ~at_limit;
        meas_load = rise;
        tout_load = ~rise & at_limit;
      end
      default: begin
        cnt_run = 1'b0;
      end
    endcase
  end

  // ---- stage p2: period and high-time counters ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      hi  <= '0;
    end else if (cnt_clr) begin
      cnt <= CW'(1);
      hi  <= CW'(1);
    end else if (cnt_run) begin
      cnt <= cnt + CW'(1);
      hi  <= hi + CW'(s);
    end
  end

  // ---- stage p3: result registers, updated together with the valid strobe ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      period     <= '0;
      high_count <= '0;
      bright     <= '0;
    end else begin
      valid <= meas_load | tout_load;
      if (meas_load) begin
        period     <= cnt;
        high_count <= hi;
        bright     <= sat_bright(hi);
      end else if (tout_load) begin
        period     <= '0;
        high_count <= stuck_high(s);
        bright     <= stuck_bright(s);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked  <= 1'b0;
      timeout <= 1'b0;
    end else if (rise) begin
      locked  <= 1'b1;
      timeout <= 1'b0;
    end else if (tout_load) begin
      locked  <= 1'b0;
      timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: an event-level model of the line is checked every cycle,
// and literal expectations are checked at the end of each scenario.
module tb_pwm_decode;

  localparam int BITS = 8;
  localparam int SYNC = 2;
  localparam int MAXP = 511;
  localparam int NSAMP = 16384;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in = 1'b0;
  logic [BITS-1:0] bright;
  logic [BITS:0]   high_count;
  logic [BITS:0]   period;
  logic            valid;
  logic            locked;
  logic            timeout;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  int v0 = 0;

  // model state: line samples per clock since reset release, and what is known about the line
  int samp [0:NSAMP-1];
  int k = 0;
  int mode = 0;        // 0 = nothing seen yet, 1 = measuring, 2 = stuck
  int since = 0;       // cycles since last accepted rising edge (or reset)
  int hsum = 0;        // high cycles seen since that edge
  int e_valid = 0, e_locked = 0, e_timeout = 0;
  int e_bright = 0, e_high = 0, e_period = 0;

  pwm_decode #(.BITS(BITS), .SYNC(SYNC), .MAX_PERIOD(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .bright(bright), .high_count(high_count),
    .period(period), .valid(valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int line_at(input int j);
    return (j >= 1 && j < NSAMP) ? samp[j] : 0;
  endfunction

  task automatic model_reset();
    k = 0; mode = 0; since = 0; hsum = 0;
    e_valid = 0; e_locked = 0; e_timeout = 0;
    e_bright = 0; e_high = 0; e_period = 0;
  endtask

  task automatic model_step();
    int s_now;
    int s_old;
    bit seen_rise;
    k = k + 1;
    // the decoder sees the pin SYNC clocks late; edges count only once SYNC+1 clocks have passed
    s_now = line_at(k - SYNC);
    s_old = line_at(k - SYNC - 1);
    if (k < NSAMP) samp[k] = int'(in);
    seen_rise = (s_now == 1) && (s_old == 0) && (k - 1 >= SYNC + 1);
    e_valid = 0;
    if (seen_rise) begin
      if (mode == 1) begin
        e_valid  = 1;
        e_period = since;
        e_high   = hsum;
        e_bright = (hsum > 255) ? 255 : hsum;
      end
      mode = 1; e_locked = 1; e_timeout = 0;
      since = 1; hsum = 1;
    end else if (mode != 2 && since == MAXP) begin
      e_valid   = 1;
      e_period  = 0;
      e_high    = s_now ? MAXP : 0;
      e_bright  = s_now ? 255 : 0;
      e_timeout = 1; e_locked = 0;
      mode = 2;
    end else if (mode != 2) begin
      since = since + 1;
      hsum  = hsum + s_now;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        total = total + 1;
        if (int'(valid) != e_valid || int'(locked) != e_locked || int'(timeout) != e_timeout ||
            int'(bright) != e_bright || int'(high_count) != e_high || int'(period) != e_period) begin
          bad = bad + 1;
          $display("FAIL cycle t=%0t got v=%0d lk=%0d to=%0d br=%0d hc=%0d per=%0d want v=%0d lk=%0d to=%0d br=%0d hc=%0d per=%0d",
                   $time, valid, locked, timeout, bright, high_count, period,
                   e_valid, e_locked, e_timeout, e_bright, e_high, e_period);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid) vcount = vcount + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      in = 1'b1;
      repeat (h) @(negedge clk);
      in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    #2 reset_n = 1'b0;
    in = v;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int br, input int hc, input int per,
                         input int lk, input int to);
    chk({tag, "_bright"}, int'(bright), br);
    chk({tag, "_high"}, int'(high_count), hc);
    chk({tag, "_period"}, int'(period), per);
    chk({tag, "_locked"}, int'(locked), lk);
    chk({tag, "_timeout"}, int'(timeout), to);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst_valid", int'(valid), 0);
    reset_n = 1'b1;
    hold(1'b0, 8);

    // duty 64 of 256
    v0 = vcount;
    pwm(64, 256, 4);
    chk("A_valids", vcount - v0, 3);
    chk_out("A", 64, 64, 256, 1, 0);
    chk("A_model_period", e_period, 256);

    // duty 255 of 256
    v0 = vcount;
    pwm(255, 256, 3);
    chk("B_valids", vcount - v0, 3);
    chk_out("B", 255, 255, 256, 1, 0);

    // line drops and stays low
    v0 = vcount;
    hold(1'b0, 600);
    chk("C_valids", vcount - v0, 1);
    chk_out("C", 0, 0, 0, 0, 1);

    // held low from reset
    do_reset(1'b0);
    v0 = vcount;
    hold(1'b0, 600);
    chk("D_valids", vcount - v0, 1);
    chk_out("D", 0, 0, 0, 0, 1);

    // recovery from stuck low with duty 128
    v0 = vcount;
    pwm(128, 256, 3);
    chk("E_valids", vcount - v0, 2);
    chk_out("E", 128, 128, 256, 1, 0);
    chk("E_model_high", e_high, 128);

    // held high across reset release
    do_reset(1'b1);
    v0 = vcount;
    hold(1'b1, 600);
    chk("F_valids", vcount - v0, 1);
    chk_out("F", 255, 511, 0, 0, 1);
    chk("F_model_high", e_high, 511);

    // reset in the middle of a period
    do_reset(1'b0);
    hold(1'b0, 8);
    pwm(64, 256, 2);
    in = 1'b1;
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_out("G_async", 0, 0, 0, 0, 0);
    chk("G_async_valid", int'(valid), 0);
    in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold(1'b0, 8);
    v0 = vcount;
    pwm(64, 256, 3);
    chk("G_valids", vcount - v0, 2);
    chk_out("G", 64, 64, 256, 1, 0);

    // longer period with high time above full scale saturates bright
    v0 = vcount;
    pwm(300, 400, 3);
    chk("H_valids", vcount - v0, 3);
    chk_out("H", 255, 300, 400, 1, 0);
    chk("H_model_bright", e_bright, 255);

    hold(1'b0, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
